// File: rtl/ucie_ctl_phy_sb_arbiter_pkg.sv
// Shared types and constants for the UCIe sideband arbiter slice.
package ucie_ctl_phy_sb_arbiter_pkg;

  // Default sideband payload width in bits.
  localparam int NC_DEFAULT = 16;

  // Arbiter FSM encoding; the numeric values are visible on the debug port.
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_NOCRD    = 2'd2
  } sb_state_t;

  // Link-management message codes carried in the low nibble of a message slot.
  localparam logic [3:0] MSG_NOP        = 4'h0;
  localparam logic [3:0] MSG_LINK_REQ   = 4'h1;
  localparam logic [3:0] MSG_LINK_RSP   = 4'h2;
  localparam logic [3:0] MSG_RETRAIN    = 4'h3;
  localparam logic [3:0] MSG_ACTIVE_REQ = 4'h5;
  localparam logic [3:0] MSG_ACTIVE_RSP = 4'h7;
  localparam logic [3:0] MSG_PM_REQ     = 4'h9;
  localparam logic [3:0] MSG_ERR        = 4'hC;

endpackage

// File: rtl/ucie_ctl_phy_credit_cnt.sv
// Remote receive-credit counter: saturating at 0, drops returns at the
// maximum and flags them with a registered one-cycle overflow pulse.
module ucie_ctl_phy_credit_cnt #(
  parameter int CRED_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic [3:0] count_next,
  output logic       overflow
);

  localparam logic [3:0] CMAX = 4'(CRED_MAX);

  logic ovf_next;

  // Next count: a simultaneous inc and dec cancel out.
  always_comb begin
    count_next = count;
    ovf_next   = 1'b0;
    if (inc && !dec) begin
      if (count == CMAX) ovf_next = 1'b1;
      else               count_next = count + 4'd1;
    end else if (dec && !inc) begin
      if (count != 4'd0) count_next = count - 4'd1;
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= CMAX;
      overflow <= 1'b0;
    end else begin
      count    <= count_next;
      overflow <= ovf_next;
    end
  end

endmodule

// File: rtl/ucie_ctl_phy_sb_arbiter.sv
// Sideband arbiter: shares one registered transmit slot between link-management
// messages (preferred) and config flits, with a streak limit that keeps config
// from starving, and remote credit flow control.
//
// Handshake: a requester's *_ready is combinational and high only in the cycle
// its request is granted; the transfer happens when valid and ready are both
// high on a clock edge. The transmit slot is offered with o_tx_valid and taken
// by the sink on any edge where i_tx_ready is high; the slot contents hold
// stable while o_tx_valid is high and i_tx_ready is low.
module ucie_ctl_phy_sb_arbiter
  import ucie_ctl_phy_sb_arbiter_pkg::*;
#(
  parameter int NC         = NC_DEFAULT,
  parameter int CRED_MAX   = 4,
  parameter int MAX_CONSEC = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_msg_valid,
  input  logic [3:0]    i_msg_code,
  output logic          o_msg_ready,
  input  logic          i_cfg_valid,
  input  logic [NC-1:0] i_cfg_data,
  output logic          o_cfg_ready,
  output logic          o_tx_valid,
  output logic          o_tx_is_msg,
  output logic [NC-1:0] o_tx_data,
  input  logic          i_tx_ready,
  input  logic          i_crd_return,
  output logic [3:0]    o_credits,
  output logic          o_crd_overflow,
  output logic [1:0]    o_state
);

  localparam int SW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);

  sb_state_t     state;
  logic [SW-1:0] streak;
  logic [3:0]    credits_next;
  logic          slot_free;
  logic          can_grant;
  logic          cfg_wins;
  logic          msg_grant;
  logic          cfg_grant;
  logic          grant;

  // Grant decision: messages first unless config has waited out a full streak.
  always_comb begin
    slot_free = !o_tx_valid || i_tx_ready;
    can_grant = (state == ST_ACTIVE) && slot_free && (o_credits != 4'd0);
    cfg_wins  = i_cfg_valid && (streak == SW'(MAX_CONSEC));
    msg_grant = can_grant && i_msg_valid && !cfg_wins;
    cfg_grant = can_grant && i_cfg_valid && (cfg_wins || !i_msg_valid);
    grant     = msg_grant || cfg_grant;
  end

  assign o_msg_ready = msg_grant;
  assign o_cfg_ready = cfg_grant;
  assign o_state     = state;

  ucie_ctl_phy_credit_cnt #(
    .CRED_MAX (CRED_MAX)
  ) u_credit_cnt (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .inc        (i_crd_return),
    .dec        (grant),
    .count      (o_credits),
    .count_next (credits_next),
    .overflow   (o_crd_overflow)
  );

  // Link FSM and message streak counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_DISABLED;
      streak <= '0;
    end else begin
      case (state)
        ST_DISABLED: begin
          if (i_enable) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!i_enable)                 state <= ST_DISABLED;
          else if (credits_next == 4'd0) state <= ST_NOCRD;
        end
        ST_NOCRD: begin
          if (!i_enable)         state <= ST_DISABLED;
          else if (i_crd_return) state <= ST_ACTIVE;
        end
        default: state <= ST_DISABLED;
      endcase

      if (state == ST_DISABLED)        streak <= '0;
      else if (cfg_grant)              streak <= '0;
      else if (msg_grant) begin
        if (i_cfg_valid) streak <= streak + 1'b1;
        else             streak <= '0;
      end
    end
  end

  // Transmit slot: load on grant, drain when the sink takes it, else hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_valid  <= 1'b0;
      o_tx_is_msg <= 1'b0;
      o_tx_data   <= '0;
    end else if (msg_grant) begin
      o_tx_valid  <= 1'b1;
      o_tx_is_msg <= 1'b1;
      o_tx_data   <= {{(NC-4){1'b0}}, i_msg_code};
    end else if (cfg_grant) begin
      o_tx_valid  <= 1'b1;
      o_tx_is_msg <= 1'b0;
      o_tx_data   <= i_cfg_data;
    end else if (o_tx_valid && i_tx_ready) begin
      o_tx_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ucie_ctl_phy_sb_arbiter.sv
// Directed bench for the sideband arbiter.
module tb_ucie_ctl_phy_sb_arbiter;
  import ucie_ctl_phy_sb_arbiter_pkg::*;

  localparam int NC = 16;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          msg_valid;
  logic [3:0]    msg_code;
  logic          msg_ready;
  logic          cfg_valid;
  logic [NC-1:0] cfg_data;
  logic          cfg_ready;
  logic          tx_valid;
  logic          tx_is_msg;
  logic [NC-1:0] tx_data;
  logic          tx_ready;
  logic          crd_return;
  logic [3:0]    credits;
  logic          crd_overflow;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;
  int n_grants;
  logic [NC:0] exp_q[$];
  logic [NC:0] exp_slot;

  ucie_ctl_phy_sb_arbiter #(
    .NC         (NC),
    .CRED_MAX   (4),
    .MAX_CONSEC (3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_msg_valid    (msg_valid),
    .i_msg_code     (msg_code),
    .o_msg_ready    (msg_ready),
    .i_cfg_valid    (cfg_valid),
    .i_cfg_data     (cfg_data),
    .o_cfg_ready    (cfg_ready),
    .o_tx_valid     (tx_valid),
    .o_tx_is_msg    (tx_is_msg),
    .o_tx_data      (tx_data),
    .i_tx_ready     (tx_ready),
    .i_crd_return   (crd_return),
    .o_credits      (credits),
    .o_crd_overflow (crd_overflow),
    .o_state        (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; msg_valid = 1'b0; msg_code = MSG_NOP;
    cfg_valid = 1'b0; cfg_data = '0; tx_ready = 1'b0; crd_return = 1'b0;
    step(); step();
    crd_return = 1'b1;
    settle();
    // Reset values
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_is_msg", 32'(tx_is_msg), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_credits", 32'(credits), 32'd4);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_overflow", 32'(crd_overflow), 32'd0);
    crd_return = 1'b0;
    rst_n = 1'b1;
    step();

    // First message: no grant while still DISABLED, then latency 1
    enable = 1'b1; msg_valid = 1'b1; msg_code = MSG_ACTIVE_REQ; tx_ready = 1'b1;
    settle();
    check_eq("first_cycle_no_grant", 32'(msg_ready), 32'd0);
    step();
    check_eq("state_active", 32'(state), 32'd1);
    check_eq("msg_ready_grant", 32'(msg_ready), 32'd1);
    check_eq("cfg_ready_idle", 32'(cfg_ready), 32'd0);
    step();
    msg_valid = 1'b0;
    check_eq("msg1_tx_valid", 32'(tx_valid), 32'd1);
    check_eq("msg1_is_msg", 32'(tx_is_msg), 32'd1);
    check_eq("msg1_data", 32'(tx_data), 32'h5);
    check_eq("msg1_credits", 32'(credits), 32'd3);
    step();
    check_eq("msg1_drain", 32'(tx_valid), 32'd0);

    // Fairness: three messages then one config while both wait
    exp_q.push_back({1'b1, 16'h0002});
    exp_q.push_back({1'b1, 16'h0002});
    exp_q.push_back({1'b1, 16'h0002});
    exp_q.push_back({1'b0, 16'hA5C3});
    exp_q.push_back({1'b1, 16'h0002});
    msg_valid = 1'b1; msg_code = MSG_LINK_RSP; cfg_valid = 1'b1; cfg_data = 16'hA5C3;
    crd_return = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      exp_slot = exp_q[0];
      check_eq($sformatf("fair_msg_ready_%0d", i), 32'(msg_ready), 32'(exp_slot[NC]));
      check_eq($sformatf("fair_cfg_ready_%0d", i), 32'(cfg_ready), 32'(!exp_slot[NC]));
      step();
      exp_slot = exp_q.pop_front();
      check_eq($sformatf("fair_slot_%0d", i), {15'd0, tx_valid, tx_is_msg, tx_data},
               {15'd0, 1'b1, exp_slot});
    end
    msg_valid = 1'b0; cfg_valid = 1'b0; crd_return = 1'b0;
    check_eq("fair_credits", 32'(credits), 32'd3);
    step();
    check_eq("fair_drain", 32'(tx_valid), 32'd0);

    // Credit exhaustion and recovery
    do_reset();
    msg_valid = 1'b1; msg_code = MSG_ACTIVE_RSP;
    n_grants = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (msg_ready) n_grants++;
      step();
    end
    check_eq("nocrd_grant_count", 32'(n_grants), 32'd4);
    check_eq("nocrd_state", 32'(state), 32'd2);
    check_eq("nocrd_credits", 32'(credits), 32'd0);
    check_eq("nocrd_no_ready", 32'(msg_ready), 32'd0);
    crd_return = 1'b1;
    settle();
    check_eq("nocrd_ret_no_ready", 32'(msg_ready), 32'd0);
    step();
    crd_return = 1'b0;
    check_eq("recover_state", 32'(state), 32'd1);
    check_eq("recover_credits", 32'(credits), 32'd1);
    settle();
    check_eq("recover_ready", 32'(msg_ready), 32'd1);
    step();
    msg_valid = 1'b0;
    check_eq("recover_slot", {30'd0, tx_valid, tx_is_msg}, 32'd3);
    check_eq("recover_data", 32'(tx_data), 32'h7);
    check_eq("recover_credits0", 32'(credits), 32'd0);
    check_eq("recover_nocrd", 32'(state), 32'd2);

    // Credit overflow at the maximum
    enable = 1'b0;
    do_reset();
    crd_return = 1'b1;
    step();
    check_eq("ovf_pulse", 32'(crd_overflow), 32'd1);
    check_eq("ovf_credits", 32'(credits), 32'd4);
    crd_return = 1'b0;
    step();
    check_eq("ovf_clear", 32'(crd_overflow), 32'd0);
    check_eq("ovf_credits_hold", 32'(credits), 32'd4);

    // Backpressure: slot holds, readies low, then drain/reload in one cycle
    enable = 1'b1;
    step();
    msg_valid = 1'b1; msg_code = MSG_RETRAIN; tx_ready = 1'b0;
    step();
    msg_code = MSG_PM_REQ;
    check_eq("bp_loaded", 32'(tx_data), 32'h3);
    settle();
    check_eq("bp_msg_ready", 32'(msg_ready), 32'd0);
    check_eq("bp_cfg_ready", 32'(cfg_ready), 32'd0);
    step();
    check_eq("bp_data_stable", 32'(tx_data), 32'h3);
    check_eq("bp_credits", 32'(credits), 32'd3);
    tx_ready = 1'b1;
    settle();
    check_eq("bp_release_ready", 32'(msg_ready), 32'd1);
    step();
    msg_valid = 1'b0;
    check_eq("bp_reload", {15'd0, tx_valid, tx_is_msg, tx_data}, {15'd0, 2'b11, 16'h0009});
    check_eq("bp_reload_credits", 32'(credits), 32'd2);

    // Reset mid-transfer
    msg_valid = 1'b1; msg_code = MSG_ERR;
    step();
    check_eq("pre_rst_valid", 32'(tx_data), 32'hC);
    rst_n = 1'b0;
    settle();
    check_eq("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("midrst_credits", 32'(credits), 32'd4);
    check_eq("midrst_state", 32'(state), 32'd0);
    step();
    rst_n = 1'b1;
    settle();
    check_eq("post_rst_no_grant", 32'(msg_ready), 32'd0);
    step();
    check_eq("post_rst_grant", 32'(msg_ready), 32'd1);

    // Disable drops back to DISABLED; config grant alone
    msg_valid = 1'b0; cfg_valid = 1'b1; cfg_data = 16'h1234;
    step();
    cfg_valid = 1'b0; enable = 1'b0; msg_code = MSG_LINK_REQ;
    check_eq("cfg_only_slot", {15'd0, tx_valid, tx_is_msg, tx_data}, {15'd0, 2'b10, 16'h1234});
    step();
    check_eq("disable_state", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
